// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: duty width, FSM encoding
// and the target clamp used when a host command is accepted.
package pwm_pkg;

   localparam int DUTY_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2
   } state_e;

   function automatic logic [DUTY_W-1:0] clamp_duty(
      input logic [DUTY_W-1:0] target,
      input logic [DUTY_W-1:0] limit
   );
      return (target > limit) ? limit : target;
   endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// Free-running PWM period counter with period-end strobe and a registered
// compare output; everything freezes and the output is forced low while ena is low.
module pwm_period_gen
   import pwm_pkg::*;
#(
   parameter int DUTY_MAX = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DUTY_W-1:0] duty,
   output logic              period_end,
   output logic              pwm_out
);

   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(DUTY_MAX - 1);

   logic [DUTY_W-1:0] cnt_q;
   logic [DUTY_W-1:0] cnt_d;
   logic              pwm_q;

   assign period_end = ena && (cnt_q == CNT_LAST);
   assign cnt_d      = period_end ? '0 : cnt_q + DUTY_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else if (ena) begin
         cnt_q <= cnt_d;
         pwm_q <= (cnt_q < duty);
      end else begin
         pwm_q <= 1'b0;
      end
   end

   // Gate with ena so the pin drops in the same cycle the design is disabled.
   assign pwm_out = pwm_q & ena;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty controller: accepts a target duty from a host command or inc/dec
// pulses and ramps the applied duty one step every STEP_PERIODS periods.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int DUTY_MAX     = 10,
   parameter int DUTY_INIT    = 5,
   parameter int STEP_PERIODS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              cmd_valid,
   input  logic [DUTY_W-1:0] cmd_target,
   output logic              cmd_ready,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
   output logic              pwm_out,
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              done,
   output state_e            dbg_state
);

   localparam logic [DUTY_W-1:0] DUTY_LIM  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] DUTY_RST  = DUTY_W'(DUTY_INIT);
   localparam int                STEP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

   state_e            state_q;
   logic [DUTY_W-1:0] duty_q;
   logic [DUTY_W-1:0] target_q;
   logic [STEP_W-1:0] step_q;
   logic              done_q;

   logic [DUTY_W-1:0] duty_d;
   logic [DUTY_W-1:0] cmd_tgt_d;
   logic              period_end;

   pwm_period_gen #(
      .DUTY_MAX (DUTY_MAX)
   ) u_period_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .duty       (duty_q),
      .period_end (period_end),
      .pwm_out    (pwm_out)
   );

   assign cmd_tgt_d = clamp_duty(cmd_target, DUTY_LIM);
   assign duty_d    = (state_q == ST_RAMP_DOWN) ? duty_q - DUTY_W'(1) : duty_q + DUTY_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         duty_q   <= DUTY_RST;
         target_q <= DUTY_RST;
         step_q   <= '0;
         done_q   <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Command beats inc, inc beats dec; inc+dec together cancel out.
               if (cmd_valid) begin
                  target_q <= cmd_tgt_d;
                  step_q   <= '0;
                  if (cmd_tgt_d > duty_q) begin
                     state_q <= ST_RAMP_UP;
                  end else if (cmd_tgt_d < duty_q) begin
                     state_q <= ST_RAMP_DOWN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end else if (inc_pulse && !dec_pulse && (duty_q != DUTY_LIM)) begin
                  target_q <= duty_q + DUTY_W'(1);
                  step_q   <= '0;
                  state_q  <= ST_RAMP_UP;
               end else if (dec_pulse && !inc_pulse && (duty_q != '0)) begin
                  target_q <= duty_q - DUTY_W'(1);
                  step_q   <= '0;
                  state_q  <= ST_RAMP_DOWN;
               end
            end
            ST_RAMP_UP, ST_RAMP_DOWN: begin
               // Duty only moves on a period end, so the waveform never glitches.
               if (period_end) begin
                  if (step_q == STEP_LAST) begin
                     step_q <= '0;
                     duty_q <= duty_d;
                     if (duty_d == target_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     step_q <= step_q + STEP_W'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end else begin
         done_q <= 1'b0;
      end
   end

   assign cmd_ready = ena && (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
   assign done      = done_q;
   assign duty      = duty_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a table of commands/pulses with hand-derived final
// duty, busy length and done expectation, plus reset, ena and ignore corner cases.
module tb_pwm_ramp_ctrl;
   import pwm_pkg::*;

   localparam int DUTY_MAX     = 10;
   localparam int DUTY_INIT    = 5;
   localparam int STEP_PERIODS = 4;

   localparam int K_CMD  = 0;
   localparam int K_INC  = 1;
   localparam int K_DEC  = 2;
   localparam int K_BOTH = 3;
   localparam int P_NONE = 0;
   localparam int P_DEC  = 1;
   localparam int P_ENA  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        cmd_valid;
   logic [3:0]  cmd_target;
   logic        cmd_ready;
   logic        inc_pulse;
   logic        dec_pulse;
   logic        pwm_out;
   logic [3:0]  duty;
   logic        busy;
   logic        done;
   state_e      dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int phase;
   logic [3:0] prev_duty;

   // {done expected, final duty, busy cycles}
   logic [16:0] exp_q[$];

   typedef struct {
      int         kind;
      int         val;
      int         poke;
      logic [3:0] e_duty;
      int         e_busy;
      bit         e_done;
   } vec_t;

   vec_t vecs[12];

   pwm_ramp_ctrl #(
      .DUTY_MAX     (DUTY_MAX),
      .DUTY_INIT    (DUTY_INIT),
      .STEP_PERIODS (STEP_PERIODS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .cmd_valid  (cmd_valid),
      .cmd_target (cmd_target),
      .cmd_ready  (cmd_ready),
      .inc_pulse  (inc_pulse),
      .dec_pulse  (dec_pulse),
      .pwm_out    (pwm_out),
      .duty       (duty),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // clock / reset / period phase reference
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase <= 0;
      else if (ena) phase <= (phase == DUTY_MAX - 1) ? 0 : phase + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Duty may only move on the edge that wraps the period counter.
   always @(negedge clk) begin
      if (rst_n && (duty != prev_duty)) check("duty_change_at_period_end", phase, 0);
      prev_duty = duty;
   end

   task automatic reset_dut();
      rst_n      = 1'b0;
      ena        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_target = 4'd0;
      inc_pulse  = 1'b0;
      dec_pulse  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic align_and_drive(input int kind, input int val);
      int n = 0;
      @(negedge clk);
      while (phase != DUTY_MAX - 1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("align_phase", phase, DUTY_MAX - 1);
      check("cmd_ready_idle", int'(cmd_ready), 1);
      case (kind)
         K_CMD:  begin cmd_valid = 1'b1; cmd_target = 4'(val); end
         K_INC:  inc_pulse = 1'b1;
         K_DEC:  dec_pulse = 1'b1;
         default: begin inc_pulse = 1'b1; dec_pulse = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      inc_pulse = 1'b0;
      dec_pulse = 1'b0;
   endtask

   task automatic run_vec(input int kind, input int val, input int poke,
                          input logic [3:0] e_duty, input int e_busy, input bit e_done);
      logic [16:0] rec;
      int busy_n = 0;
      int n = 0;
      int limit;
      int highs = 0;
      bit got_done = 0;
      logic [3:0] held;
      exp_q.push_back({e_done, e_duty, 12'(e_busy)});
      align_and_drive(kind, val);
      limit = e_done ? 2000 : 15;
      while (!got_done && n < limit) begin
         @(negedge clk);
         n++;
         if (ena && busy) busy_n++;
         if (done) got_done = 1;
         if (!ena) begin
            check("ena_low_outputs", int'({pwm_out, cmd_ready, done}), 0);
            check("ena_low_duty_held", int'(duty), int'(held));
         end
         if (poke == P_DEC) begin
            if (n == 50) dec_pulse = 1'b1;
            if (n == 51) dec_pulse = 1'b0;
         end else if (poke == P_ENA) begin
            if (n == 50) begin ena = 1'b0; held = duty; end
            if (n == 75) ena = 1'b1;
         end
      end
      check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         rec = exp_q.pop_front();
         check("done_seen", int'(got_done), int'(rec[16]));
         check("final_duty", int'(duty), int'(rec[15:12]));
         check("busy_cycles", busy_n, int'(rec[11:0]));
      end
      if (got_done) begin
         @(negedge clk);
         check("done_one_cycle", int'({done, busy}), 0);
      end
      for (int i = 0; i < DUTY_MAX; i++) begin
         @(negedge clk);
         highs += int'(pwm_out);
      end
      check("pwm_high_count", highs, int'(e_duty));
   endtask

   initial begin
      int highs;
      int n;
      bit seen;

      vecs[0]  = '{K_CMD,  8,  P_NONE, 4'd8,  120, 1'b1};
      vecs[1]  = '{K_BOTH, 0,  P_NONE, 4'd8,  0,   1'b0};
      vecs[2]  = '{K_CMD,  15, P_NONE, 4'd10, 80,  1'b1};
      vecs[3]  = '{K_INC,  0,  P_NONE, 4'd10, 0,   1'b0};
      vecs[4]  = '{K_CMD,  10, P_NONE, 4'd10, 0,   1'b1};
      vecs[5]  = '{K_DEC,  0,  P_NONE, 4'd9,  40,  1'b1};
      vecs[6]  = '{K_CMD,  0,  P_NONE, 4'd0,  360, 1'b1};
      vecs[7]  = '{K_DEC,  0,  P_NONE, 4'd0,  0,   1'b0};
      vecs[8]  = '{K_INC,  0,  P_NONE, 4'd1,  40,  1'b1};
      vecs[9]  = '{K_CMD,  3,  P_NONE, 4'd3,  80,  1'b1};
      vecs[10] = '{K_CMD,  3,  P_NONE, 4'd3,  0,   1'b1};
      vecs[11] = '{K_CMD,  12, P_NONE, 4'd10, 280, 1'b1};

      reset_dut();
      check("rst_duty", int'(duty), DUTY_INIT);
      check("rst_flags", int'({busy, done}), 0);
      check("rst_state", int'(dbg_state), int'(ST_IDLE));
      check("rst_cmd_ready", int'(cmd_ready), 1);
      highs = 0;
      for (int i = 0; i < 2 * DUTY_MAX; i++) begin
         @(negedge clk);
         highs += int'(pwm_out);
      end
      check("idle_pwm_50pct", highs, 2 * DUTY_INIT);

      // one K_BOTH at duty 5 first, then the table
      run_vec(K_BOTH, 0, P_NONE, 4'd5, 0, 1'b0);
      for (int i = 0; i < 12; i++)
         run_vec(vecs[i].kind, vecs[i].val, vecs[i].poke, vecs[i].e_duty, vecs[i].e_busy, vecs[i].e_done);

      // dec pulse mid-ramp is ignored; ena low freezes the ramp
      reset_dut();
      run_vec(K_CMD, 2, P_DEC, 4'd2, 120, 1'b1);
      run_vec(K_CMD, 5, P_ENA, 4'd5, 120, 1'b1);

      // reset in the middle of a 5->8 ramp, once duty has reached 7
      reset_dut();
      align_and_drive(K_CMD, 8);
      n = 0;
      while (duty != 4'd7 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("midramp_reached_7", int'(duty), 7);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_duty", int'(duty), DUTY_INIT);
      check("async_rst_flags", int'({busy, done, pwm_out}), 0);
      check("async_rst_cmd_ready", int'(cmd_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy || done || duty != 4'(DUTY_INIT)) seen = 1;
      end
      check("ramp_abandoned", int'(seen), 0);
      run_vec(K_CMD, 6, P_NONE, 4'd6, 40, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_MAX, default 10, meaning PWM period length in clocks and maximum duty value.
REQ-002 SHALL have parameter DUTY_INIT, default 5, meaning duty value after reset (50%).
REQ-003 SHALL have parameter STEP_PERIODS, default 4, meaning PWM periods between successive ramp steps.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1, design enable; low freezes all state.
REQ-007 SHALL have port cmd_valid, input, 1, host requests a new duty target.
REQ-008 SHALL have port cmd_target, input, 4, requested target duty.
REQ-009 SHALL have port cmd_ready, output, 1, controller accepts a command this cycle.
REQ-010 SHALL have port inc_pulse, input, 1, debounced single-cycle increase request.
REQ-011 SHALL have port dec_pulse, input, 1, debounced single-cycle decrease request.
REQ-012 SHALL have port pwm_out, output, 1, PWM waveform.
REQ-013 SHALL have port duty, output, 4, currently applied duty.
REQ-014 SHALL have port busy, output, 1, ramp in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when ramp reaches target.

Function
REQ-016 SHALL run period counter 0..DUTY_MAX-1, wrapping to 0; period end = counter at DUTY_MAX-1 with ena high.
REQ-017 SHALL drive pwm_out = (period counter < duty), registered, so duty 0 gives constant 0 and duty DUTY_MAX gives constant 1.
REQ-018 SHALL change duty only at a period end (glitch-free update), never mid-period.
REQ-019 SHALL implement states IDLE, RAMP_UP, RAMP_DOWN.
REQ-020 SHALL assert cmd_ready only in IDLE with ena high; accept on cmd_valid&&cmd_ready.
REQ-021 SHALL clamp accepted cmd_target above DUTY_MAX to DUTY_MAX.
REQ-022 SHALL, on accept, go RAMP_UP if target>duty, RAMP_DOWN if target<duty, else stay IDLE and pulse done next cycle.
REQ-023 SHALL in IDLE, with no command accepted, treat inc_pulse alone as target=min(duty+1,DUTY_MAX) and dec_pulse alone as target=max(duty-1,0); priority cmd > inc > dec.
REQ-024 SHALL ignore inc_pulse and dec_pulse when both high in the same cycle, and at duty limits (no state change, no done).
REQ-025 SHALL ignore inc_pulse/dec_pulse outside IDLE (no queuing).
REQ-026 SHALL in RAMP states count period ends in a step counter; at the STEP_PERIODS-th period end apply duty±1 and clear the step counter.
REQ-027 SHALL, on the period end where duty becomes target, return to IDLE and pulse done for exactly one clock on the following cycle.
REQ-028 SHALL hold busy high exactly while in RAMP_UP or RAMP_DOWN.
REQ-029 SHALL with ena low hold all counters, state and duty, force pwm_out 0, cmd_ready 0, done 0.

Reset
REQ-030 SHALL on rst_n low asynchronously set state IDLE, period and step counters 0, duty DUTY_INIT, pwm_out 0, busy 0, done 0; cmd_ready follows state/ena.
REQ-031 SHALL abandon any ramp on reset mid-operation; first behaviour after release is from IDLE.

Structure
REQ-032 SHALL place state encoding and 4-bit duty width constant in shared package pwm_pkg.
REQ-033 SHALL use one sub-module pwm_period_gen (period counter, period-end strobe, compare output); FSM and step counter in top.

Verification
REQ-034 Reset release, idle -> duty 5, pwm_out high 5 of every 10 clocks, cmd_ready 1.
REQ-035 Command target 8 from duty 5 -> busy for 12 periods (120 clocks), duty 6,7,8 at period ends 4,8,12, then one done pulse.
REQ-036 Command target 15 -> clamped, ramps to 10; pwm_out constant 1 afterwards.
REQ-037 inc_pulse and dec_pulse same cycle at duty 5 -> no change, no busy, no done.
REQ-038 dec_pulse during ramp 5->2 -> ignored; ramp completes at 2 unchanged timing.
REQ-039 rst_n low mid-ramp at duty 7 -> immediate duty 5, busy 0, IDLE.
